// File: rtl/mul_datapath_if.sv
// Control/status bundle between the multiplier control FSM and the shift-add datapath.
// The master side is the controller; the slave side is the datapath.
interface mul_datapath_if #(
    parameter int WIDTH = 32
);
    logic                   Load;
    logic                   Sh;
    logic                   Ad;
    logic [WIDTH-1:0]       Multiplicand;
    logic [WIDTH-1:0]       Multiplier;
    logic                   K;
    logic                   M;
    logic [2*WIDTH-1:0]     Product;
    logic                   PValid;

    modport master (
        output Load, Sh, Ad, Multiplicand, Multiplier,
        input  K, M, Product, PValid
    );

    modport slave (
        input  Load, Sh, Ad, Multiplicand, Multiplier,
        output K, M, Product, PValid
    );
endinterface

// File: rtl/mul_datapath.sv
// Shift-add multiplier datapath: accumulator/multiplier register, iteration counter and a
// product holding register that keeps the last result across idle-state reloads.
module mul_datapath #(
    parameter int WIDTH = 32
) (
    input  logic            Clk,
    input  logic            Reset,
    mul_datapath_if.slave   io_dp
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int AW = 2 * WIDTH + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    logic [AW-1:0]          r_acc;
    logic [CW-1:0]          r_count;
    logic [2*WIDTH-1:0]     r_product;
    logic                   r_pvalid;

    logic [AW-1:0]          w_acc_nxt;
    logic [CW-1:0]          w_count_nxt;
    logic [2*WIDTH-1:0]     w_product_nxt;
    logic                   w_pvalid_nxt;
    logic [AW-1:0]          w_acc_shr;
    logic [WIDTH-1:0]       w_load_hi;
    logic [WIDTH:0]         w_sum;

    // Bit 0 of the multiplier is folded in at load time, so only WIDTH-1 adds remain.
    assign w_load_hi = io_dp.Multiplier[0] ? io_dp.Multiplicand : {WIDTH{1'b0}};
    assign w_acc_shr = {1'b0, r_acc[AW-1:1]};
    assign w_sum     = {1'b0, r_acc[AW-2:WIDTH]} + {1'b0, io_dp.Multiplicand};

    // Next-state selection with Load > Sh > Ad priority.
    always_comb begin
        w_acc_nxt     = r_acc;
        w_count_nxt   = r_count;
        w_product_nxt = r_product;
        w_pvalid_nxt  = r_pvalid;
        if (io_dp.Load) begin
            w_acc_nxt   = {1'b0, w_load_hi, io_dp.Multiplier};
            w_count_nxt = CNT_FULL;
        end else if (io_dp.Sh) begin
            if (r_count != CNT_ZERO) begin
                w_acc_nxt   = w_acc_shr;
                w_count_nxt = r_count - CNT_ONE;
                // Last-shift set is tested first so it wins when first and last coincide.
                if (r_count == CNT_ONE) begin
                    w_product_nxt = w_acc_shr[2*WIDTH-1:0];
                    w_pvalid_nxt  = 1'b1;
                end else if (r_count == CNT_FULL) begin
                    w_pvalid_nxt  = 1'b0;
                end else begin
                    w_pvalid_nxt  = r_pvalid;
                end
            end else begin
                w_acc_nxt   = r_acc;
                w_count_nxt = r_count;
            end
        end else if (io_dp.Ad) begin
            w_acc_nxt = {w_sum, r_acc[WIDTH-1:0]};
        end else begin
            w_acc_nxt = r_acc;
        end
    end

    // Datapath state registers, cleared asynchronously by Reset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_acc     <= {AW{1'b0}};
            r_count   <= CNT_ZERO;
            r_product <= {(2*WIDTH){1'b0}};
            r_pvalid  <= 1'b0;
        end else begin
            r_acc     <= w_acc_nxt;
            r_count   <= w_count_nxt;
            r_product <= w_product_nxt;
            r_pvalid  <= w_pvalid_nxt;
        end
    end

    assign io_dp.K       = (r_count == CNT_ZERO);
    assign io_dp.M       = r_acc[0];
    assign io_dp.Product = r_product;
    assign io_dp.PValid  = r_pvalid;
endmodule

// File: tb/tb_mul_datapath.sv
// Self-checking bench: drives the standard shift/check control sequence and compares
// status bits and products against an arithmetic reference (A*B, multiplier bits).
module tb_mul_datapath;
    localparam int W = 32;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic [63:0] last_prod;
    logic        last_valid;

    mul_datapath_if #(.WIDTH(W)) bus32 ();
    mul_datapath_if #(.WIDTH(1)) bus1 ();

    mul_datapath #(.WIDTH(W)) dut32 (.Clk(clk), .Reset(rst), .io_dp(bus32));
    mul_datapath #(.WIDTH(1)) dut1  (.Clk(clk), .Reset(rst), .io_dp(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation under standard control; n_sh < W abandons it early.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int n_sh,
                          input bit all_strobes);
        logic [63:0] prod;
        prod = 64'(a) * 64'(b);
        bus32.Multiplicand = a;
        bus32.Multiplier   = b;
        bus32.Load = 1'b1;
        bus32.Sh   = all_strobes;
        bus32.Ad   = all_strobes;
        tick();
        bus32.Load = 1'b0;
        bus32.Sh   = 1'b0;
        bus32.Ad   = 1'b0;
        check_eq("k_load", 64'(bus32.K), 64'(0));
        check_eq("m_load", 64'(bus32.M), 64'(b[0]));
        check_eq("prod_keep_load", bus32.Product, last_prod);
        check_eq("pv_keep_load", 64'(bus32.PValid), 64'(last_valid));
        for (int k = 1; k <= n_sh; k++) begin
            bus32.Sh = 1'b1;
            tick();
            bus32.Sh = 1'b0;
            if (k == W) begin
                last_prod  = prod;
                last_valid = 1'b1;
                check_eq($sformatf("k_sh%0d", k), 64'(bus32.K), 64'(1));
                check_eq($sformatf("m_sh%0d", k), 64'(bus32.M), 64'(prod[0]));
                check_eq("product", bus32.Product, prod);
                check_eq("pvalid", 64'(bus32.PValid), 64'(1));
            end else begin
                last_valid = 1'b0;
                check_eq($sformatf("k_sh%0d", k), 64'(bus32.K), 64'(0));
                check_eq($sformatf("m_sh%0d", k), 64'(bus32.M), 64'(b[k]));
                check_eq($sformatf("prod_hold_sh%0d", k), bus32.Product, last_prod);
                check_eq($sformatf("pv_sh%0d", k), 64'(bus32.PValid), 64'(0));
                bus32.Ad = b[k];
                tick();
                bus32.Ad = 1'b0;
            end
        end
    endtask

    // Idle state: Load held with fresh operands must not disturb the held result.
    task automatic hold_load(input int n, input logic [31:0] a, input logic [31:0] b);
        bus32.Multiplicand = a;
        bus32.Multiplier   = b;
        bus32.Load = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            check_eq($sformatf("idle_prod%0d", i), bus32.Product, last_prod);
            check_eq($sformatf("idle_pv%0d", i), 64'(bus32.PValid), 64'(last_valid));
            check_eq($sformatf("idle_k%0d", i), 64'(bus32.K), 64'(0));
        end
        bus32.Load = 1'b0;
        bus32.Sh   = 1'b1;
        tick();
        bus32.Sh   = 1'b0;
        last_valid = 1'b0;
        check_eq("first_sh_pv", 64'(bus32.PValid), 64'(0));
        check_eq("first_sh_prod", bus32.Product, last_prod);
        check_eq("first_sh_m", 64'(bus32.M), 64'(b[1]));
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        n_checks   = 0;
        n_errors   = 0;
        last_prod  = 64'd0;
        last_valid = 1'b0;
        rst = 1'b1;
        bus32.Load = 1'b0; bus32.Sh = 1'b0; bus32.Ad = 1'b0;
        bus32.Multiplicand = 32'd0; bus32.Multiplier = 32'd0;
        bus1.Load = 1'b0; bus1.Sh = 1'b0; bus1.Ad = 1'b0;
        bus1.Multiplicand = 1'b0; bus1.Multiplier = 1'b0;
        tick();
        tick();
        check_eq("rst_k", 64'(bus32.K), 64'(1));
        check_eq("rst_m", 64'(bus32.M), 64'(0));
        check_eq("rst_prod", bus32.Product, 64'd0);
        check_eq("rst_pv", 64'(bus32.PValid), 64'(0));
        rst = 1'b0;
        tick();

        run_op(32'd3, 32'd5, W, 1'b0);
        hold_load(3, 32'hDEAD_BEEF, 32'h0000_0006);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, W, 1'b0);
        run_op(32'h1234_5678, 32'h0000_0000, W, 1'b0);
        hold_load(10, 32'h1234_5678, 32'h0000_0000);

        // Sh with Count==0 leaves every register alone.
        run_op(32'd11, 32'd13, W, 1'b0);
        bus32.Sh = 1'b1;
        tick();
        tick();
        bus32.Sh = 1'b0;
        check_eq("sh0_prod", bus32.Product, 64'd143);
        check_eq("sh0_pv", 64'(bus32.PValid), 64'(1));
        check_eq("sh0_k", 64'(bus32.K), 64'(1));
        check_eq("sh0_m", 64'(bus32.M), 64'(1));

        // Load with Sh and Ad strobed together behaves as a pure Load.
        run_op(32'h0001_F00D, 32'h8000_0003, W, 1'b1);

        // Asynchronous reset in the middle of an operation.
        run_op(32'd7, 32'd9, 10, 1'b0);
        rst = 1'b1;
        #1;
        check_eq("arst_k", 64'(bus32.K), 64'(1));
        check_eq("arst_m", 64'(bus32.M), 64'(0));
        check_eq("arst_pv", 64'(bus32.PValid), 64'(0));
        check_eq("arst_prod", bus32.Product, 64'd0);
        #1;
        rst = 1'b0;
        last_prod  = 64'd0;
        last_valid = 1'b0;
        run_op(32'd7, 32'd9, W, 1'b0);
        check_eq("restart_63", bus32.Product, 64'd63);

        // Randomized operations, every fourth one preceded by an abandoned operation.
        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
            if ((i % 4) == 3) begin
                run_op(rb, ra, $urandom_range(1, W - 1), 1'b0);
            end
            run_op(ra, rb, W, 1'b0);
        end

        // WIDTH=1 instance.
        check_eq("w1_rst_pv", 64'(bus1.PValid), 64'(0));
        check_eq("w1_rst_k", 64'(bus1.K), 64'(1));
        bus1.Multiplicand = 1'b1;
        bus1.Multiplier   = 1'b1;
        bus1.Load = 1'b1;
        tick();
        bus1.Load = 1'b0;
        check_eq("w1_load_k", 64'(bus1.K), 64'(0));
        check_eq("w1_load_m", 64'(bus1.M), 64'(1));
        bus1.Sh = 1'b1;
        tick();
        bus1.Sh = 1'b0;
        check_eq("w1_prod_11", 64'(bus1.Product), 64'(1));
        check_eq("w1_pv_11", 64'(bus1.PValid), 64'(1));
        check_eq("w1_k_11", 64'(bus1.K), 64'(1));
        bus1.Multiplier = 1'b0;
        bus1.Load = 1'b1;
        tick();
        bus1.Load = 1'b0;
        check_eq("w1_hold_prod", 64'(bus1.Product), 64'(1));
        check_eq("w1_hold_pv", 64'(bus1.PValid), 64'(1));
        bus1.Sh = 1'b1;
        tick();
        bus1.Sh = 1'b0;
        check_eq("w1_prod_10", 64'(bus1.Product), 64'(0));
        check_eq("w1_pv_10", 64'(bus1.PValid), 64'(1));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
